// File: rtl/axil_regfile_slave_if.sv
// rtl/axil_regfile_slave_if.sv - AXI4-Lite bus bundle between a master and the register file slave
interface axil_regfile_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   s3_axi_awaddr;
   logic                    s3_axi_awvalid;
   logic                    s3_axi_awready;
   logic [DATA_WIDTH-1:0]   s3_axi_wdata;
   logic [DATA_WIDTH/8-1:0] s3_axi_wstrb;
   logic                    s3_axi_wvalid;
   logic                    s3_axi_wready;
   logic [1:0]              s3_axi_bresp;
   logic                    s3_axi_bvalid;
   logic                    s3_axi_bready;
   logic [ADDR_WIDTH-1:0]   s3_axi_araddr;
   logic                    s3_axi_arvalid;
   logic                    s3_axi_arready;
   logic [DATA_WIDTH-1:0]   s3_axi_rdata;
   logic [1:0]              s3_axi_rresp;
   logic                    s3_axi_rvalid;
   logic                    s3_axi_rready;

   modport slave (
      input  s3_axi_awaddr, s3_axi_awvalid, s3_axi_wdata, s3_axi_wstrb, s3_axi_wvalid,
      input  s3_axi_bready, s3_axi_araddr, s3_axi_arvalid, s3_axi_rready,
      output s3_axi_awready, s3_axi_wready, s3_axi_bresp, s3_axi_bvalid,
      output s3_axi_arready, s3_axi_rdata, s3_axi_rresp, s3_axi_rvalid
   );

   modport master (
      output s3_axi_awaddr, s3_axi_awvalid, s3_axi_wdata, s3_axi_wstrb, s3_axi_wvalid,
      output s3_axi_bready, s3_axi_araddr, s3_axi_arvalid, s3_axi_rready,
      input  s3_axi_awready, s3_axi_wready, s3_axi_bresp, s3_axi_bvalid,
      input  s3_axi_arready, s3_axi_rdata, s3_axi_rresp, s3_axi_rvalid
   );
endinterface

// File: rtl/axil_regfile_slave.sv
// rtl/axil_regfile_slave.sv - AXI4-Lite register file with byte strobes, RO status slots and SLVERR decode
module axil_regfile_slave #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    NUM_REGS   = 8,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           s3_axi_aclk,
   input  logic                           s3_axi_aresetn,
   axil_regfile_slave_if.slave            s_axi,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);
   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t              r_wstate, w_wstate_nxt;
   r_state_t              r_rstate, w_rstate_nxt;
   logic                  r_live;
   logic                  r_aw_held, r_w_held;
   logic [IDX_W-1:0]      r_aw_idx;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic [STRB_W-1:0]     r_w_strb;
   logic [1:0]            r_bresp, r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_wr_pulse;

   logic                  w_aw_hs, w_w_hs, w_ar_hs;
   logic                  w_commit, w_wr_ok, w_rd_ok;
   logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
   logic [DATA_WIDTH-1:0] w_wr_data, w_rd_data;
   logic [STRB_W-1:0]     w_wr_strb;
   logic [NUM_REGS-1:0]   w_wr_sel;

   // r_live keeps every ready low until the first edge after reset release
   assign s_axi.s3_axi_awready = r_live && !r_aw_held && (r_wstate == W_IDLE);
   assign s_axi.s3_axi_wready  = r_live && !r_w_held  && (r_wstate == W_IDLE);
   assign s_axi.s3_axi_arready = r_live && (r_rstate == R_IDLE);
   assign s_axi.s3_axi_bvalid  = (r_wstate == W_RESP);
   assign s_axi.s3_axi_bresp   = r_bresp;
   assign s_axi.s3_axi_rvalid  = (r_rstate == R_DATA);
   assign s_axi.s3_axi_rresp   = r_rresp;
   assign s_axi.s3_axi_rdata   = r_rdata;
   assign reg_wr_pulse         = r_wr_pulse;

   assign w_aw_hs = s_axi.s3_axi_awvalid && s_axi.s3_axi_awready;
   assign w_w_hs  = s_axi.s3_axi_wvalid  && s_axi.s3_axi_wready;
   assign w_ar_hs = s_axi.s3_axi_arvalid && s_axi.s3_axi_arready;

   // Commit as soon as both halves are available, counting a handshake on this edge
   assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
   assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axi.s3_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
   assign w_wr_data = r_w_held ? r_w_data : s_axi.s3_axi_wdata;
   assign w_wr_strb = r_w_held ? r_w_strb : s_axi.s3_axi_wstrb;
   assign w_rd_idx  = s_axi.s3_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

   generate
      if (ADDR_LSB > 0) begin : g_lsb
         logic w_lsb_unused;
         assign w_lsb_unused = ^{s_axi.s3_axi_awaddr[ADDR_LSB-1:0], s_axi.s3_axi_araddr[ADDR_LSB-1:0]};
      end
   endgenerate

   always_comb begin
      w_wr_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_wr_idx == IDX_W'(i) && !RO_MASK[i]) w_wr_sel[i] = 1'b1;
      end
   end
   assign w_wr_ok = |w_wr_sel;

   always_comb begin
      w_rd_data = '0;
      w_rd_ok   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_rd_idx == IDX_W'(i)) begin
            w_rd_ok   = 1'b1;
            w_rd_data = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
         end
      end
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
         W_RESP:  if (s_axi.s3_axi_bready) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
         R_DATA:  if (s_axi.s3_axi_rready) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
      if (!s3_axi_aresetn) begin
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
         r_live   <= 1'b0;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
         r_live   <= 1'b1;
      end
   end

   always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
      if (!s3_axi_aresetn) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_aw_idx   <= '0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_bresp    <= RESP_OKAY;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= '0;
         r_wr_pulse <= '0;
      end else begin
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_aw_idx  <= s_axi.s3_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_w_data <= s_axi.s3_axi_wdata;
               r_w_strb <= s_axi.s3_axi_wstrb;
            end
         end
         r_wr_pulse <= w_commit ? w_wr_sel : '0;
         if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
      if (!s3_axi_aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      end else if (w_commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (w_wr_sel[i] && w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
         assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : r_regs[g];
      end
   endgenerate
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb/tb_axil_regfile_slave.sv - vector table plus scoreboard bench for axil_regfile_slave
module tb_axil_regfile_slave;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axil_regfile_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   logic [NR*DW-1:0] status_in;
   logic [NR*DW-1:0] reg_out;
   logic [NR-1:0]    reg_wr_pulse;

   axil_regfile_slave #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
      .RO_MASK(8'h80), .RESET_VAL(32'h0)
   ) dut (
      .s3_axi_aclk(clk),
      .s3_axi_aresetn(rst_n),
      .s_axi(bus.slave),
      .status_in(status_in),
      .reg_out(reg_out),
      .reg_wr_pulse(reg_wr_pulse)
   );

   typedef struct {
      logic        rd;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;
   typedef struct { logic [1:0] resp; logic [NR-1:0] pulse; } bexp_t;
   typedef struct { logic [1:0] resp; logic [31:0] data; } rexp_t;

   bexp_t bq[$];
   rexp_t rq[$];
   vec_t  tbl[16];
   int    n_vec = 0;
   int    n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.s3_axi_bvalid && bus.s3_axi_bready) begin
         if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
         else begin
            bexp_t be;
            be = bq.pop_front();
            chk("bresp", 64'(bus.s3_axi_bresp), 64'(be.resp));
            chk("wr_pulse", 64'(reg_wr_pulse), 64'(be.pulse));
         end
      end
      if (rst_n && bus.s3_axi_rvalid && bus.s3_axi_rready) begin
         if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
         else begin
            rexp_t re;
            re = rq.pop_front();
            chk("rresp", 64'(bus.s3_axi_rresp), 64'(re.resp));
            chk("rdata", 64'(bus.s3_axi_rdata), 64'(re.data));
         end
      end
   end

   task automatic wait_b();
      int n = 0;
      @(negedge clk);
      while (!bus.s3_axi_bvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("b_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_r();
      int n = 0;
      @(negedge clk);
      while (!bus.s3_axi_rvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("r_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      logic aw_ok, w_ok;
      bus.s3_axi_awaddr = a; bus.s3_axi_wdata = d; bus.s3_axi_wstrb = s;
      bus.s3_axi_awvalid = 1'b1; bus.s3_axi_wvalid = 1'b1;
      while ((bus.s3_axi_awvalid || bus.s3_axi_wvalid) && n < 50) begin
         @(negedge clk);
         aw_ok = bus.s3_axi_awready; w_ok = bus.s3_axi_wready;
         @(posedge clk); #1;
         if (aw_ok) bus.s3_axi_awvalid = 1'b0;
         if (w_ok)  bus.s3_axi_wvalid  = 1'b0;
         n++;
      end
      if (n >= 50) begin
         chk("aw_w_timeout", 64'd0, 64'd1);
         bus.s3_axi_awvalid = 1'b0; bus.s3_axi_wvalid = 1'b0;
      end
      wait_b();
   endtask

   task automatic do_read(input logic [7:0] a);
      int n = 0;
      logic ar_ok;
      bus.s3_axi_araddr = a; bus.s3_axi_arvalid = 1'b1;
      while (bus.s3_axi_arvalid && n < 50) begin
         @(negedge clk);
         ar_ok = bus.s3_axi_arready;
         @(posedge clk); #1;
         if (ar_ok) bus.s3_axi_arvalid = 1'b0;
         n++;
      end
      if (n >= 50) begin chk("ar_timeout", 64'd0, 64'd1); bus.s3_axi_arvalid = 1'b0; end
      wait_r();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b0, 8'h08, 32'h12345678, 4'hF, 2'b00, 32'h0};
      tbl[1]  = '{1'b1, 8'h08, 32'h0,        4'h0, 2'b00, 32'h12345678};
      tbl[2]  = '{1'b0, 8'h0C, 32'hFFFFFFFF, 4'h3, 2'b00, 32'h0};
      tbl[3]  = '{1'b1, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h0000FFFF};
      tbl[4]  = '{1'b0, 8'h0C, 32'hA5A5A5A5, 4'h8, 2'b00, 32'h0};
      tbl[5]  = '{1'b1, 8'h0E, 32'h0,        4'h0, 2'b00, 32'hA500FFFF};
      tbl[6]  = '{1'b0, 8'h40, 32'h11111111, 4'hF, 2'b10, 32'h0};
      tbl[7]  = '{1'b1, 8'h40, 32'h0,        4'h0, 2'b10, 32'h0};
      tbl[8]  = '{1'b0, 8'h1C, 32'h00000055, 4'hF, 2'b10, 32'h0};
      tbl[9]  = '{1'b1, 8'h1C, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
      tbl[10] = '{1'b0, 8'h10, 32'hCAFE0000, 4'h0, 2'b00, 32'h0};
      tbl[11] = '{1'b1, 8'h10, 32'h0,        4'h0, 2'b00, 32'h0};
      tbl[12] = '{1'b0, 8'h18, 32'h0BADF00D, 4'hF, 2'b00, 32'h0};
      tbl[13] = '{1'b1, 8'h18, 32'h0,        4'h0, 2'b00, 32'h0BADF00D};
      tbl[14] = '{1'b1, 8'hFC, 32'h0,        4'h0, 2'b10, 32'h0};
      tbl[15] = '{1'b1, 8'h08, 32'h0,        4'h0, 2'b00, 32'h12345678};

      status_in = '0;
      for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = 32'h5000_0000 + 32'(i);
      status_in[7*DW +: DW] = 32'hDEADBEEF;
      bus.s3_axi_awaddr = '0; bus.s3_axi_awvalid = 1'b0;
      bus.s3_axi_wdata = '0; bus.s3_axi_wstrb = '0; bus.s3_axi_wvalid = 1'b0;
      bus.s3_axi_bready = 1'b1; bus.s3_axi_araddr = '0; bus.s3_axi_arvalid = 1'b0;
      bus.s3_axi_rready = 1'b1;

      // reset state and ready release
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_bvalid",  64'(bus.s3_axi_bvalid), 64'd0);
      chk("rst_rvalid",  64'(bus.s3_axi_rvalid), 64'd0);
      chk("rst_awready", 64'(bus.s3_axi_awready), 64'd0);
      chk("rst_wready",  64'(bus.s3_axi_wready), 64'd0);
      chk("rst_arready", 64'(bus.s3_axi_arready), 64'd0);
      chk("rst_bresp",   64'(bus.s3_axi_bresp), 64'd0);
      chk("rst_rresp",   64'(bus.s3_axi_rresp), 64'd0);
      chk("rst_rdata",   64'(bus.s3_axi_rdata), 64'd0);
      chk("rst_reg_out", 64'(|reg_out), 64'd0);
      chk("rst_pulse",   64'(reg_wr_pulse), 64'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_awready", 64'(bus.s3_axi_awready), 64'd1);
      chk("rel_wready",  64'(bus.s3_axi_wready), 64'd1);
      chk("rel_arready", 64'(bus.s3_axi_arready), 64'd1);

      // same-cycle AW + W
      #1;
      bus.s3_axi_awaddr = 8'h00; bus.s3_axi_wdata = 32'h19; bus.s3_axi_wstrb = 4'hF;
      bus.s3_axi_awvalid = 1'b1; bus.s3_axi_wvalid = 1'b1;
      bq.push_back('{2'b00, 8'h01});
      @(posedge clk); #1;
      bus.s3_axi_awvalid = 1'b0; bus.s3_axi_wvalid = 1'b0;
      @(negedge clk);
      chk("same_bvalid", 64'(bus.s3_axi_bvalid), 64'd1);
      chk("same_pulse",  64'(reg_wr_pulse), 64'h01);
      chk("same_reg0",   64'(reg_out[31:0]), 64'h19);
      @(negedge clk);
      chk("same_bvalid_drop", 64'(bus.s3_axi_bvalid), 64'd0);
      chk("same_pulse_drop",  64'(reg_wr_pulse), 64'd0);

      // W two cycles ahead of AW, partial strobe
      @(posedge clk); #1;
      bq.push_back('{2'b00, 8'h02});
      do_write(8'h04, 32'h22, 4'hF);
      bus.s3_axi_wdata = 32'hAABBCCDD; bus.s3_axi_wstrb = 4'h5; bus.s3_axi_wvalid = 1'b1;
      bq.push_back('{2'b00, 8'h02});
      @(posedge clk); #1;
      bus.s3_axi_wvalid = 1'b0;
      @(negedge clk);
      chk("wfirst_wready",  64'(bus.s3_axi_wready), 64'd0);
      chk("wfirst_awready", 64'(bus.s3_axi_awready), 64'd1);
      chk("wfirst_bvalid",  64'(bus.s3_axi_bvalid), 64'd0);
      @(negedge clk);
      chk("wfirst_reg1_hold", 64'(reg_out[63:32]), 64'h22);
      #1;
      bus.s3_axi_awaddr = 8'h04; bus.s3_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      bus.s3_axi_awvalid = 1'b0;
      @(negedge clk);
      chk("wfirst_bvalid_on", 64'(bus.s3_axi_bvalid), 64'd1);
      chk("wfirst_reg1",      64'(reg_out[63:32]), 64'h00BB00DD);
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].rd) begin
            rq.push_back('{tbl[i].resp, tbl[i].rdata});
            do_read(tbl[i].addr);
         end else begin
            bexp_t e;
            e.resp  = tbl[i].resp;
            e.pulse = (tbl[i].resp == 2'b00) ? (8'h01 << tbl[i].addr[4:2]) : 8'h00;
            bq.push_back(e);
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
         end
      end
      chk("ro_slice_zero", 64'(reg_out[255:224]), 64'd0);
      chk("reg3_final",    64'(reg_out[127:96]), 64'hA500FFFF);
      chk("reg4_strb0",    64'(reg_out[159:128]), 64'd0);

      // read held while rready low
      bus.s3_axi_rready = 1'b0;
      bus.s3_axi_araddr = 8'h08; bus.s3_axi_arvalid = 1'b1;
      rq.push_back('{2'b00, 32'h12345678});
      @(posedge clk); #1;
      bus.s3_axi_arvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_rvalid",  64'(bus.s3_axi_rvalid), 64'd1);
         chk("hold_rdata",   64'(bus.s3_axi_rdata), 64'h12345678);
         chk("hold_arready", 64'(bus.s3_axi_arready), 64'd0);
      end
      @(posedge clk); #1;
      bus.s3_axi_rready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("hold_arready_back", 64'(bus.s3_axi_arready), 64'd1);
      chk("hold_rvalid_drop",  64'(bus.s3_axi_rvalid), 64'd0);

      // reset while a write response is pending
      #1;
      bus.s3_axi_bready = 1'b0;
      bus.s3_axi_awaddr = 8'h14; bus.s3_axi_wdata = 32'h77; bus.s3_axi_wstrb = 4'hF;
      bus.s3_axi_awvalid = 1'b1; bus.s3_axi_wvalid = 1'b1;
      @(posedge clk); #1;
      bus.s3_axi_awvalid = 1'b0; bus.s3_axi_wvalid = 1'b0;
      @(negedge clk);
      chk("pre_rst_bvalid", 64'(bus.s3_axi_bvalid), 64'd1);
      chk("pre_rst_reg5",   64'(reg_out[191:160]), 64'h77);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_bvalid",  64'(bus.s3_axi_bvalid), 64'd0);
      chk("mid_rst_regs",    64'(|reg_out), 64'd0);
      chk("mid_rst_awready", 64'(bus.s3_axi_awready), 64'd0);
      chk("mid_rst_pulse",   64'(reg_wr_pulse), 64'd0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      bus.s3_axi_bready = 1'b1;
      @(negedge clk);
      chk("post_rst_awready", 64'(bus.s3_axi_awready), 64'd1);
      chk("post_rst_wready",  64'(bus.s3_axi_wready), 64'd1);
      chk("post_rst_arready", 64'(bus.s3_axi_arready), 64'd1);
      chk("post_rst_bvalid",  64'(bus.s3_axi_bvalid), 64'd0);

      chk("bq_drained", 64'(bq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
